// File: rtl/cand_gen_pkg.sv
// Shared state encoding, LFSR polynomial and seed helper for cand_vector_gen.
package cand_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    CHECK,
    HOLD,
    DONE
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/galois_lfsr.sv
// Right-shifting Galois LFSR with parallel load; resets to 1 so it never starts locked.
module galois_lfsr #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WIDTH'(1);
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= {1'b0, state[WIDTH-1:1]} ^ (state[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/cand_vector_gen.sv
// Random candidate generator feeding an external combinational checker.
// Optional CAND_VECTOR_GEN_FORCE_EN adds force_mask/force_val to pin candidate bits.
module cand_vector_gen
  import cand_gen_pkg::*;
#(
  parameter int VEC_W     = 384,
  parameter int LFSR_W    = 32,
  parameter int NUM_SOL   = 1,
  parameter int MAX_TRIES = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  output logic [VEC_W-1:0]  cand,
  input  logic              sat,
  output logic              sol_valid,
  input  logic              sol_ready,
  output logic [VEC_W-1:0]  sol_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       tries,
  output logic [15:0]       hits
`ifdef CAND_VECTOR_GEN_FORCE_EN
  ,
  input  logic [VEC_W-1:0]  force_mask,
  input  logic [VEC_W-1:0]  force_val
`endif
);

  localparam int NCHUNK = (VEC_W + LFSR_W - 1) / LFSR_W;
  localparam int CNT_W  = $clog2(NCHUNK + 1);

  state_t            state_q, state_d;
  logic              timeout_q, timeout_d;
  logic [VEC_W-1:0]  cand_q;
  logic [VEC_W-1:0]  cand_out;
  logic [VEC_W-1:0]  sol_data_q;
  logic [CNT_W-1:0]  chunk_q;
  logic [31:0]       tries_q, tries_inc;
  logic [15:0]       hits_q, hits_inc;
  logic [LFSR_W-1:0] lfsr;
  logic              start_ok, last_chunk;

`ifdef CAND_VECTOR_GEN_FORCE_EN
  assign cand_out = (cand_q & ~force_mask) | (force_val & force_mask);
`else
  assign cand_out = cand_q;
`endif

  assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_chunk = (chunk_q == CNT_W'(NCHUNK - 1));
  assign tries_inc  = (tries_q == 32'hFFFF_FFFF) ? tries_q : tries_q + 32'd1;
  assign hits_inc   = hits_q + 16'd1;

  galois_lfsr #(
    .WIDTH (LFSR_W),
    .TAPS  (LFSR_W'(LFSR_TAPS))
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_ok),
    .load_val (LFSR_W'(seed_fix(32'(seed)))),
    .step     (state_q == FILL),
    .state    (lfsr)
  );

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = FILL;
          timeout_d = 1'b0;
        end
      end
      FILL: begin
        if (last_chunk) state_d = CHECK;
      end
      CHECK: begin
        if (sat) begin
          state_d = HOLD;
        end else if (tries_inc == 32'(MAX_TRIES)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          state_d = FILL;
        end
      end
      HOLD: begin
        if (sol_ready) begin
          if (hits_inc == 16'(NUM_SOL)) begin
            state_d   = DONE;
            timeout_d = 1'b0;
          end else if (tries_q == 32'(MAX_TRIES)) begin
            state_d   = DONE;
            timeout_d = 1'b1;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers; the LFSR and sol_data only move in FILL and CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timeout_q  <= 1'b0;
      cand_q     <= '0;
      sol_data_q <= '0;
      chunk_q    <= '0;
      tries_q    <= '0;
      hits_q     <= '0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      if (start_ok) begin
        tries_q <= '0;
        hits_q  <= '0;
        chunk_q <= '0;
      end
      case (state_q)
        FILL: begin
          cand_q  <= {cand_q[VEC_W-LFSR_W-1:0], lfsr};
          chunk_q <= last_chunk ? '0 : chunk_q + CNT_W'(1);
        end
        CHECK: begin
          tries_q <= tries_inc;
          if (sat) sol_data_q <= cand_out;
        end
        HOLD: begin
          if (sol_ready) hits_q <= hits_inc;
        end
        default: ;
      endcase
    end
  end

  assign cand      = cand_out;
  assign sol_data  = sol_data_q;
  assign sol_valid = (state_q == HOLD);
  assign busy      = (state_q == FILL) || (state_q == CHECK) || (state_q == HOLD);
  assign done      = (state_q == DONE);
  assign timeout   = timeout_q;
  assign tries     = tries_q;
  assign hits      = hits_q;

endmodule

// File: tb/tb_cand_vector_gen.sv
// Randomized bench for cand_vector_gen with a per-try reference model of the search.
module tb_cand_vector_gen;

  localparam int VEC_W     = 384;
  localparam int LFSR_W    = 32;
  localparam int NUM_SOL   = 3;
  localparam int MAX_TRIES = 4;
  localparam int NCHUNK    = (VEC_W + LFSR_W - 1) / LFSR_W;
  localparam int BUDGET    = 2000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [LFSR_W-1:0] seed = '0;
  logic [VEC_W-1:0]  cand;
  logic              sat;
  logic              sol_valid;
  logic              sol_ready = 1'b0;
  logic [VEC_W-1:0]  sol_data;
  logic              busy, done, timeout;
  logic [31:0]       tries;
  logic [15:0]       hits;
  int                sat_mode = 0;
  logic [1:0]        pat = 2'd0;
  int                checks = 0;
  int                passes = 0;
`ifdef CAND_VECTOR_GEN_FORCE_EN
  logic [VEC_W-1:0]  force_mask = '0;
  logic [VEC_W-1:0]  force_val = '0;
`endif

  always #5 clk = ~clk;

  // Checker stand-in: never, always, or a 1-in-4 predicate on the low bits.
  assign sat = (sat_mode == 0) ? 1'b0 :
               (sat_mode == 1) ? 1'b1 : (cand[1:0] == pat);

  cand_vector_gen #(
    .VEC_W     (VEC_W),
    .LFSR_W    (LFSR_W),
    .NUM_SOL   (NUM_SOL),
    .MAX_TRIES (MAX_TRIES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed      (seed),
    .cand      (cand),
    .sat       (sat),
    .sol_valid (sol_valid),
    .sol_ready (sol_ready),
    .sol_data  (sol_data),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .tries     (tries),
    .hits      (hits)
`ifdef CAND_VECTOR_GEN_FORCE_EN
    ,
    .force_mask (force_mask),
    .force_val  (force_val)
`endif
  );

  task automatic checkOutput(input string tag, input logic [VEC_W-1:0] got,
                             input logic [VEC_W-1:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] lfsrNext(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic bit satOf(input logic [VEC_W-1:0] v);
    if (sat_mode == 0) return 1'b0;
    if (sat_mode == 1) return 1'b1;
    return v[1:0] == pat;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits for a visible event; optionally fires a stray start three cycles in.
  task automatic waitEvent(output int n, input bit poke);
    n = 0;
    while (n < BUDGET) begin
      cycle();
      n++;
      if (poke && n == 3) start = 1'b1;
      if (poke && n == 3) seed = $urandom;
      if (poke && n == 4) start = 1'b0;
      if (sol_valid || done) break;
    end
    start = 1'b0;
  endtask

  // One whole run: the model walks tries and predicts every visible event.
  task automatic applyStimulus(input logic [31:0] s, input int mode,
                               input int stall_max, input bit poke);
    logic [31:0]      m_lfsr;
    logic [VEC_W-1:0] exp_vec;
    int               m_tries, m_hits, n, exp_wait, k;
    bit               fin, exp_to, first;
    sat_mode = mode;
    pat      = 2'($urandom);
    m_lfsr   = (s == 32'h0) ? 32'h1 : s;
    m_tries  = 0;
    m_hits   = 0;
    exp_wait = 0;
    exp_to   = 1'b0;
    fin      = 1'b0;
    first    = 1'b1;
    seed  = s;
    start = 1'b1;
    cycle();
    start = 1'b0;
    seed  = $urandom;
    checkOutput("busy_after_start", VEC_W'(busy), VEC_W'(1));
    while (!fin) begin
      for (int c = 0; c < NCHUNK; c++) begin
        exp_vec[VEC_W-1-LFSR_W*c -: LFSR_W] = m_lfsr;
        m_lfsr = lfsrNext(m_lfsr);
      end
      m_tries++;
      exp_wait += NCHUNK + 1;
      if (satOf(exp_vec)) begin
        waitEvent(n, poke && first);
        first = 1'b0;
        checkOutput("sol_latency", VEC_W'(n), VEC_W'(exp_wait));
        if (n >= BUDGET) break;
        exp_wait = 0;
        checkOutput("sol_valid", VEC_W'(sol_valid), VEC_W'(1));
        checkOutput("sol_data", sol_data, exp_vec);
        checkOutput("tries_at_sol", VEC_W'(tries), VEC_W'(m_tries));
        k = $urandom_range(stall_max, 0);
        repeat (k) cycle();
        checkOutput("sol_data_stall", sol_data, exp_vec);
        checkOutput("sol_valid_stall", VEC_W'(sol_valid), VEC_W'(1));
        sol_ready = 1'b1;
        cycle();
        sol_ready = 1'b0;
        m_hits++;
        checkOutput("hits", VEC_W'(hits), VEC_W'(m_hits));
        checkOutput("sol_valid_drop", VEC_W'(sol_valid), VEC_W'(0));
        if (m_hits == NUM_SOL) begin
          fin = 1'b1;
          exp_to = 1'b0;
        end else if (m_tries == MAX_TRIES) begin
          fin = 1'b1;
          exp_to = 1'b1;
        end
      end else if (m_tries == MAX_TRIES) begin
        waitEvent(n, poke && first);
        checkOutput("timeout_latency", VEC_W'(n), VEC_W'(exp_wait));
        checkOutput("sol_valid_never", VEC_W'(sol_valid), VEC_W'(0));
        fin = 1'b1;
        exp_to = 1'b1;
      end
    end
    checkOutput("done", VEC_W'(done), VEC_W'(1));
    checkOutput("timeout", VEC_W'(timeout), VEC_W'(exp_to));
    checkOutput("tries_final", VEC_W'(tries), VEC_W'(m_tries));
    checkOutput("hits_final", VEC_W'(hits), VEC_W'(m_hits));
    checkOutput("busy_final", VEC_W'(busy), VEC_W'(0));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cand"}, cand, '0);
    checkOutput({tag, "_sol_data"}, sol_data, '0);
    checkOutput({tag, "_tries"}, VEC_W'(tries), '0);
    checkOutput({tag, "_hits"}, VEC_W'(hits), '0);
    checkOutput({tag, "_flags"}, VEC_W'({sol_valid, busy, done, timeout}), '0);
  endtask

  // Pulls rst_n low between edges and checks outputs before the next edge.
  task automatic asyncReset(input string tag);
    #2 rst_n = 1'b0;
    #1 checkResetValues(tag);
    #2 rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    #12;
    checkResetValues("reset");
    rst_n = 1'b1;
    cycle();

    applyStimulus(32'h1, 1, 10, 1'b0);
    applyStimulus(32'h0, 1, 3, 1'b0);
    applyStimulus($urandom, 0, 0, 1'b0);
    applyStimulus(32'h1, 1, 2, 1'b1);

    seed = $urandom;
    sat_mode = 1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    asyncReset("rst_fill");
    applyStimulus(32'h1, 1, 0, 1'b0);

    seed = $urandom;
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (NCHUNK + 1) cycle();
    checkOutput("hold_before_reset", VEC_W'(sol_valid), VEC_W'(1));
    asyncReset("rst_hold");
    applyStimulus(32'h1, 1, 1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      applyStimulus($urandom, $urandom_range(2, 0), 4, r[0]);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
